pc_redirect: RTL and testbench

// - PC register plus control-flow redirect stage. Consumes the EX-stage branch decision (cmp from the

---
 rtl/pc_redirect_pkg.sv | 24 ++
 rtl/pc_redirect_branch_target.sv | 23 ++
 rtl/pc_redirect.sv | 127 ++++++++++++
 tb/tb_pc_redirect.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
// Shared definitions for the PC redirect stage: FSM states, default widths/reset PC,
// RISC-V branch funct3 codes and opcodes. Optional macro: PC_REDIRECT_STATS_EN.
package pc_redirect_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pc_redirect_branch_target.sv
// Combinational control-transfer target and link address; JALR clears the target LSB.
module branch_target #(
  parameter int XLEN = 32
) (
  input  logic            is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link_addr
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  always_comb begin
    base      = is_jalr ? ex_rs1 : ex_pc;
    sum       = base + ex_imm;
    target    = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    link_addr = ex_pc + XLEN'(4);
  end

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC register with EX-stage redirect, flush sequencing (RUN/FLUSH) and optional
// branch statistics enabled by the PC_REDIRECT_STATS_EN macro.
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEF),
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            cmp,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_addr,
  output logic            redirect,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            misalign_exc,
  output logic [31:0]     br_total,
  output logic [31:0]     br_taken
);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] target;
  logic            take;

  branch_target #(.XLEN(XLEN)) u_target (
    .is_jalr   (ex_is_jalr),
    .ex_pc     (ex_pc),
    .ex_imm    (ex_imm),
    .ex_rs1    (ex_rs1),
    .target    (target),
    .link_addr (link_addr)
  );

  // Jumps override branches; a misaligned target turns the transfer into an exception instead.
  assign take     = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cmp)) & (state_q == ST_RUN);
  assign redirect = take & ~target[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d    = target;
          state_d = ST_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
          flush_d = 1'b1;
        end else begin
          mis_d = take;
          if (!stall) pc_d = pc_q + XLEN'(4);
        end
      end
      ST_FLUSH: begin
        pc_d = pc_q + XLEN'(4);
        if (cnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign pc           = pc_q;
  assign flush_if_id  = flush_q;
  assign flush_id_ex  = flush_q;
  assign misalign_exc = mis_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] br_total_q, br_taken_q;
  logic        br_seen;

  assign br_seen = ex_valid & ex_is_branch & (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_q <= 32'd0;
      br_taken_q <= 32'd0;
    end else begin
      if (br_seen)            br_total_q <= br_total_q + 32'd1;
      if (br_seen & redirect) br_taken_q <= br_taken_q + 32'd1;
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`else
  assign br_total = 32'd0;
  assign br_taken = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Self-checking bench for pc_redirect: sequential vector table with a scoreboard queue
// for registered outputs, plus hand-written flush-length and jump-priority sequences.
module tb_pc_redirect;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, cmp;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic [31:0] pc, link_addr, br_total, br_taken;
  logic        redirect, flush_if_id, flush_id_ex, misalign_exc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_redirect dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .cmp          (cmp),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .pc           (pc),
    .link_addr    (link_addr),
    .redirect     (redirect),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .misalign_exc (misalign_exc),
    .br_total     (br_total),
    .br_taken     (br_taken)
  );

  typedef struct {
    logic        rst, stall, valid, br, jal, jalr, cmp;
    logic [31:0] ex_pc, imm, rs1;
    logic        redir;
    logic [31:0] link;
    logic [31:0] pc_n;
    logic        flush_n, mis_n;
    logic [31:0] tot_n, tkn_n;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        flush, mis;
    logic [31:0] tot, tkn;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic s, logic v, logic b, logic j, logic jr, logic c,
                              logic [31:0] p, logic [31:0] i, logic [31:0] r1,
                              logic rd, logic [31:0] lk, logic [31:0] pn, logic fl, logic ms,
                              logic [31:0] tt, logic [31:0] tk);
    vec_t t;
    t.rst = r; t.stall = s; t.valid = v; t.br = b; t.jal = j; t.jalr = jr; t.cmp = c;
    t.ex_pc = p; t.imm = i; t.rs1 = r1; t.redir = rd; t.link = lk;
    t.pc_n = pn; t.flush_n = fl; t.mis_n = ms; t.tot_n = tt; t.tkn_n = tk;
    return t;
  endfunction

  function automatic logic [31:0] stat(logic [31:0] v);
`ifdef PC_REDIRECT_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic s, logic v, logic b, logic j, logic jr, logic c,
                       logic [31:0] p, logic [31:0] i, logic [31:0] r1);
    rst = r; stall = s; ex_valid = v; ex_is_branch = b; ex_is_jal = j; ex_is_jalr = jr;
    cmp = c; ex_pc = p; ex_imm = i; ex_rs1 = r1;
  endtask

  task automatic step(int idx, vec_t t);
    exp_t e;
    drive(t.rst, t.stall, t.valid, t.br, t.jal, t.jalr, t.cmp, t.ex_pc, t.imm, t.rs1);
    #1;
    chk($sformatf("v%0d redirect", idx), {31'd0, redirect}, {31'd0, t.redir});
    chk($sformatf("v%0d link_addr", idx), link_addr, t.link);
    e.pc = t.pc_n; e.flush = t.flush_n; e.mis = t.mis_n;
    e.tot = stat(t.tot_n); e.tkn = stat(t.tkn_n);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("v%0d pc", idx), pc, e.pc);
    chk($sformatf("v%0d flush_if_id", idx), {31'd0, flush_if_id}, {31'd0, e.flush});
    chk($sformatf("v%0d flush_id_ex", idx), {31'd0, flush_id_ex}, {31'd0, e.flush});
    chk($sformatf("v%0d misalign_exc", idx), {31'd0, misalign_exc}, {31'd0, e.mis});
    chk($sformatf("v%0d br_total", idx), br_total, e.tot);
    chk($sformatf("v%0d br_taken", idx), br_taken, e.tkn);
  endtask

  initial begin
    int nflush;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    // r s v b j jr c  ex_pc imm rs1  redir link  pc_next flush mis tot tkn
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h000, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h004, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h008, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h00C, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h010, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h010, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h010, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h014, 0,0, 0,0));
    vecs.push_back(mk(0,0,1,1,0,0,1, 32'h20, 32'h40, 32'h0, 1, 32'h24, 32'h060, 1,0, 1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h20, 32'h40, 32'h0, 0, 32'h24, 32'h064, 1,0, 1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h20, 32'h40, 32'h0, 0, 32'h24, 32'h068, 0,0, 1,1));
    vecs.push_back(mk(0,0,1,1,0,0,0, 32'h30, 32'h40, 32'h0, 0, 32'h34, 32'h06C, 0,0, 2,1));
    vecs.push_back(mk(0,0,1,0,0,1,0, 32'h40, 32'h10, 32'h101, 1, 32'h44, 32'h110, 1,0, 2,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h40, 32'h10, 32'h0, 0, 32'h44, 32'h114, 1,0, 2,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h40, 32'h10, 32'h0, 0, 32'h44, 32'h118, 0,0, 2,1));
    vecs.push_back(mk(0,0,1,0,1,0,0, 32'h50, 32'h06, 32'h0, 0, 32'h54, 32'h11C, 0,1, 2,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h50, 32'h06, 32'h0, 0, 32'h54, 32'h120, 0,0, 2,1));
    vecs.push_back(mk(0,1,1,0,1,0,0, 32'h80, 32'h100, 32'h0, 1, 32'h84, 32'h180, 1,0, 2,1));
    vecs.push_back(mk(0,1,1,1,0,0,1, 32'h90, 32'h40, 32'h0, 0, 32'h94, 32'h184, 1,0, 2,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h90, 32'h40, 32'h0, 0, 32'h94, 32'h188, 0,0, 2,1));
    vecs.push_back(mk(0,0,1,1,0,0,1, 32'h200, 32'h10, 32'h0, 1, 32'h204, 32'h210, 1,0, 3,2));
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h200, 32'h10, 32'h0, 0, 32'h204, 32'h000, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 32'h0, 0, 32'h04, 32'h004, 0,0, 0,0));
    vecs.push_back(mk(0,0,1,1,0,0,1, 32'h08, 32'h08, 32'h0, 1, 32'h0C, 32'h010, 1,0, 1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h08, 32'h08, 32'h0, 0, 32'h0C, 32'h014, 1,0, 1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h08, 32'h08, 32'h0, 0, 32'h0C, 32'h018, 0,0, 1,1));
    vecs.push_back(mk(0,0,1,0,1,0,0, 32'h10, 32'hFFFF_FFF0, 32'h0, 1, 32'h14, 32'h000, 1,0, 1,1));

    @(posedge clk); #1;
    foreach (vecs[i]) step(i, vecs[i]);

    // JALR and JAL both high: JALR target must win; then count flush cycles with a bound.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 20 && flush_if_id; k++) begin
      @(posedge clk); #1;
    end
    chk("flush drained before priority test", {31'd0, flush_if_id}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h300);
    #1;
    chk("prio redirect", {31'd0, redirect}, 32'd1);
    @(posedge clk); #1;
    chk("prio pc jalr wins", pc, 32'h300);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    nflush = 0;
    for (int k = 0; k < 20 && flush_if_id; k++) begin
      nflush++;
      @(posedge clk); #1;
    end
    chk("flush length", nflush, 32'd2);
    chk("pc after flush", pc, 32'h308);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
